// File: rtl/bus_sequencer.sv
// T-step control sequencer for the shared datapath bus: fetch plus one R-format ALU instruction.
// Optional mul/div sequencing (Zlow->LO, Zhigh->HI) is enabled by defining BUS_SEQ_MULDIV_EN.
module bus_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [23:0] bus_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for start, all controls quiet
  // T0    | PC -> MAR, Z <= PC+1
  // T1    | Zlow -> PC (first cycle only), memory read until mem_ready or timeout
  // T2    | MDR -> IR
  // T3    | decode; rb -> Y, or abort on illegal opcode
  // T4    | rc (or rb for neg/not) -> ALU, result into Z
  // T5    | Zlow -> ra, or Zlow -> LO for mul/div
  // T6    | Zhigh -> HI (mul/div only)
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  localparam logic [7:0] TO_LOAD = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic [4:0] op;
  logic [3:0] ra, rb, rc, src_b;
  logic       op_legal, op_muldiv;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign src_b     = (op == 5'd9 || op == 5'd10) ? rb : rc;

`ifdef BUS_SEQ_MULDIV_EN
  assign op_muldiv = (op == 5'd11) || (op == 5'd12);
`else
  assign op_muldiv = 1'b0;
`endif
  assign op_legal = (op <= 5'd10) || op_muldiv;

  // wait_cnt counts down the remaining T1 cycles; terminal count at zero aborts the fetch
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) state <= T0;
        T0: begin
          state    <= T1;
          wait_cnt <= TO_LOAD;
        end
        T1: begin
          if (mem_ready) begin
            state    <= T2;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'd0) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        T2: state <= T3;
        T3: begin
          if (op_legal) begin
            state <= T4;
          end else begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        T4: state <= T5;
        T5: begin
          if (op_muldiv) begin
            state <= T6;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        T6: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus_sel = 24'd0;
    reg_in  = 16'd0;
    pc_in   = 1'b0;
    ir_in   = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    alu_op  = 5'd0;
    busy    = (state != IDLE);
    case (state)
      T0: begin
        bus_sel[20] = 1'b1;
        mar_in      = 1'b1;
        inc_pc      = 1'b1;
        z_in        = 1'b1;
      end
      T1: begin
        bus_sel[19] = 1'b1;
        read        = 1'b1;
        pc_in       = (wait_cnt == TO_LOAD);
        mdr_in      = mem_ready;
      end
      T2: begin
        bus_sel[21] = 1'b1;
        ir_in       = 1'b1;
      end
      T3: begin
        if (op_legal) begin
          bus_sel[{1'b0, rb}] = 1'b1;
          y_in                = 1'b1;
        end
      end
      T4: begin
        bus_sel[{1'b0, src_b}] = 1'b1;
        alu_op                 = op;
        z_in                   = 1'b1;
      end
      T5: begin
        bus_sel[19] = 1'b1;
`ifdef BUS_SEQ_MULDIV_EN
        if (op_muldiv) lo_in = 1'b1;
        else           reg_in[ra] = 1'b1;
`else
        reg_in[ra] = 1'b1;
`endif
      end
      T6: begin
`ifdef BUS_SEQ_MULDIV_EN
        bus_sel[18] = 1'b1;
        hi_in       = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus randomized instructions
// compared cycle by cycle against a step-list model of the instruction sequence.
module tb_bus_sequencer;

  localparam int MEM_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = 32'd0;
  logic [23:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
  logic [4:0]  alu_op;
  logic        busy, done, err;

  bus_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .bus_sel(bus_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] bus_sel;
    logic [15:0] reg_in;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
    logic [4:0] alu_op;
    logic busy, done, err;
  } outs_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    last_lat = 0;
  outs_t exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic outs_t observed();
    return {bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
            inc_pc, read, alu_op, busy, done, err};
  endfunction

  function automatic bit muldiv_on();
`ifdef BUS_SEQ_MULDIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected outputs for every cycle from T0 up to and including the done/err cycle.
  // delay = number of T1 cycles without mem_ready before it arrives.
  function automatic void build(input logic [31:0] iv, input int delay);
    outs_t o;
    int op, ra, rb, rc, k;
    bit ready, md, legal;
    op = int'(iv[31:27]); ra = int'(iv[26:23]); rb = int'(iv[22:19]); rc = int'(iv[18:15]);
    md    = muldiv_on() && (op == 11 || op == 12);
    legal = (op <= 10) || md;
    exp_q.delete();
    o = '0; o.busy = 1; o.bus_sel[20] = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    exp_q.push_back(o);
    k = 0; ready = 0;
    while (!ready && k < MEM_TIMEOUT) begin
      ready = (k == delay);
      o = '0; o.busy = 1; o.bus_sel[19] = 1; o.read = 1; o.pc_in = (k == 0); o.mdr_in = ready;
      exp_q.push_back(o);
      k++;
    end
    if (!ready) begin
      o = '0; o.err = 1; exp_q.push_back(o);
      return;
    end
    o = '0; o.busy = 1; o.bus_sel[21] = 1; o.ir_in = 1; exp_q.push_back(o);
    o = '0; o.busy = 1;
    if (legal) begin o.bus_sel[rb] = 1; o.y_in = 1; end
    exp_q.push_back(o);
    if (!legal) begin
      o = '0; o.err = 1; exp_q.push_back(o);
      return;
    end
    o = '0; o.busy = 1; o.bus_sel[(op == 9 || op == 10) ? rb : rc] = 1;
    o.alu_op = 5'(op); o.z_in = 1;
    exp_q.push_back(o);
    o = '0; o.busy = 1; o.bus_sel[19] = 1;
    if (md) o.lo_in = 1; else o.reg_in[ra] = 1;
    exp_q.push_back(o);
    if (md) begin
      o = '0; o.busy = 1; o.bus_sel[18] = 1; o.hi_in = 1; exp_q.push_back(o);
    end
    o = '0; o.done = 1; exp_q.push_back(o);
  endfunction

  task automatic run_instr(input logic [31:0] iv, input int delay, input bit hold, input bit chained);
    build(iv, delay);
    last_lat = 0;
    if (!chained) begin
      @(negedge clock);
      ir = iv; start = 1'b1; mem_ready = 1'b0;
      #1;
      check_val("idle_before_start", 64'(observed()), 64'd0);
    end else begin
      ir = iv;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      mem_ready = (i == delay + 1);
      #1;
      check_val($sformatf("step%0d_op%0d_dly%0d", i, iv[31:27], delay), 64'(observed()), 64'(exp_q[i]));
      check_val("bus_onehot", 64'($countones(bus_sel) <= 1), 64'd1);
      check_val("reg_in_onehot", 64'($countones(reg_in) <= 1), 64'd1);
      if ((done || err) && last_lat == 0) last_lat = i + 1;
    end
    mem_ready = 1'b0;
  endtask

  function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
  endfunction

  logic [31:0] add_ir;
  bit          chained;

  initial begin
    add_ir = {5'd0, 4'd3, 4'd1, 4'd2, 15'd0};

    // reset: outputs quiet even with start high
    start = 1'b1; ir = mk_ir(0, 1, 2, 3);
    repeat (2) @(negedge clock);
    #1;
    check_val("reset_outputs", 64'(observed()), 64'd0);
    start = 1'b0;
    @(negedge clock);
    clear = 1'b0;

    run_instr(add_ir, 0, 1'b0, 1'b0);
    check_val("lat_add", 64'(last_lat), 64'd7);
    run_instr(add_ir, 3, 1'b0, 1'b0);
    check_val("lat_add_mem3", 64'(last_lat), 64'd10);
    run_instr(add_ir, 99, 1'b0, 1'b0);
    check_val("lat_timeout", 64'(last_lat), 64'd17);
    run_instr(add_ir, 14, 1'b0, 1'b0);
    check_val("lat_ready_last_t1", 64'(last_lat), 64'd21);
    run_instr(mk_ir(11, 5, 6, 7), 0, 1'b0, 1'b0);
    check_val("lat_mul", 64'(last_lat), muldiv_on() ? 64'd8 : 64'd5);
    run_instr(mk_ir(9, 4, 8, 2), 1, 1'b0, 1'b0);
    run_instr(mk_ir(31, 2, 3, 4), 0, 1'b1, 1'b0);
    check_val("lat_illegal", 64'(last_lat), 64'd5);
    run_instr(mk_ir(1, 7, 7, 7), 0, 1'b0, 1'b1);

    // clear in the middle of T4
    build(add_ir, 0);
    @(negedge clock);
    ir = add_ir; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      start = 1'b0;
      mem_ready = (i == 1);
      #1;
      check_val($sformatf("pre_clear_step%0d", i), 64'(observed()), 64'(exp_q[i]));
    end
    mem_ready = 1'b0;
    clear = 1'b1;
    #1;
    check_val("clear_in_t4", 64'(observed()), 64'd0);
    @(negedge clock);
    #1;
    check_val("clear_next_cycle", 64'(observed()), 64'd0);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check_val("after_clear_quiet", 64'(observed()), 64'd0);
    end

    chained = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int op, dly;
      bit hold;
      op   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 12)) : int'($urandom_range(13, 31));
      dly  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(13, 16));
      hold = 1'($urandom_range(0, 1));
      run_instr(mk_ir(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15))), dly, hold, chained);
      chained = hold;
    end
    if (chained) run_instr(mk_ir(2, 1, 2, 3), 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
